if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction fetch stage plus IF/ID pipeline register of the 8-bit pipelined microprocessor. Owns the program counter, drives the instruction-memory address, and registers the fetched word and its decoded fields for the decode stage. Its `id_imm3` output feeds the 3-bit to 8-bit immediate sign-extender directly. It supports hazard stall, branch redirect with flush, and a HALT state.

## Interface

**Parameters**
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `IW`, default 12: instruction width.
  - Field layout: opcode `[11:9]`, rd `[8:6]`, rs `[5:3]`, imm3 `[2:0]`.
- `HALT_OP`, default 3'b111: opcode that halts fetch.

**Ports**
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out 8: equals the current PC (combinational from the PC register).
- `imem_data` in IW: instruction word; asynchronous read of `imem_addr`, valid in the same cycle.
- `stall` in 1: from the hazard unit; hold PC and IF/ID contents.
- `redirect` in 1: branch or jump taken in a later stage.
- `redirect_pc` in 8: target address, sampled when `redirect` = 1.
- `id_valid` out 1: IF/ID holds a real instruction (0 = bubble).
- `id_pc` out 8: address of the instruction held in IF/ID.
- `id_pc_plus1` out 8: `id_pc + 1`, modulo 256.
- `id_instr` out IW: registered instruction word.
- `id_opcode` out 3: `id_instr[11:9]`.
- `id_rd` out 3: `id_instr[8:6]`.
- `id_rs` out 3: `id_instr[5:3]`.
- `id_imm3` out 3: `id_instr[2:0]`; goes to the sign-extender.
- `halted` out 1: fetch is stopped in the HALTED state.

## Operation

**State**
- Registers: `pc`[7:0], IF/ID {`valid`, `pc`, `instr`}, and FSM state {RUN, HALTED}.
- Decoded field outputs are pure wires from `id_instr`.

**Per-edge priority, highest first**
1. `rst`:
   - `pc` = RESET_PC, `id_valid` = 0, `id_pc` = 0, `id_instr` = 0, state = RUN, `halted` = 0.
   - Therefore `id_pc_plus1` = 1 and all field outputs = 0.
2. `redirect`:
   - `pc` = `redirect_pc`.
   - IF/ID flushed: `id_valid` = 0; `id_instr` and `id_pc` keep their old values.
   - State = RUN.
   - Overrides `stall` and the HALTED state.
3. `stall`: `pc`, IF/ID and state all hold.
4. State HALTED: `pc` holds; `id_valid` = 0 (bubble inserted every cycle).
5. State RUN, normal fetch:
   - IF/ID loads {1, `pc`, `imem_data`}.
   - If `imem_data[11:9]` == HALT_OP: `pc` holds and the next state is HALTED.
   - Otherwise: `pc` = `pc` + 1, wrapping 8'hFF → 8'h00.

**Other rules**
- The HALT instruction itself enters IF/ID with valid = 1, so it flows down the pipe. The fetched word is not otherwise decoded.
- `halted` = (state == HALTED).
- PC arithmetic is 8-bit unsigned with no carry out.

## Timing

- Fetch-to-decode latency is 1 cycle. The word at address A appears on the `id_*` outputs in the cycle after `pc` == A.
- Throughput is 1 instruction per cycle in RUN with no stall.
- Redirect:
  - Asserted in cycle N; the target word is in IF/ID at cycle N+2.
  - Exactly one bubble appears (`id_valid` = 0 at cycle N+1).
- Stall:
  - Outputs are frozen for each stalled cycle.
  - `imem_addr` is unchanged, so `imem_data` is simply re-read.
- HALT:
  - Fetched in cycle N: `halted` = 1 from cycle N+1.
  - `id_valid` = 1 in N+1 (the HALT word itself), then 0 from N+2 onward.
- Reset mid-stall, mid-redirect or while HALTED: reset wins, and the next cycle fetches from RESET_PC.
- `redirect_pc` == the current `pc` is legal: behaves as flush and refetch.

## Test plan

- **Reset and sequential fetch:** `rst` for 2 cycles; memory word at address a is {3'b000, a[2:0], 3'b001, a[2:0]}. Required response:
  - `id_valid` = 0 during reset.
  - Then `id_pc` = 0, 1, 2, … on consecutive cycles, with `id_imm3` = `id_pc[2:0]` and `id_pc_plus1` = `id_pc` + 1.
- **Stall:** `stall` for 3 cycles while `id_pc` = 5. Required response:
  - `id_pc` stays 5 and `id_instr` is unchanged; `imem_addr` stays 6.
  - When stall releases, `id_pc` = 6 follows.
- **Redirect with flush:** `redirect` = 1 with `redirect_pc` = 8'h40 at `pc` = 8'h10, `stall` = 1 in the same cycle. Required response:
  - Next cycle: `id_valid` = 0 and `imem_addr` = 8'h40.
  - The cycle after: `id_pc` = 8'h40 with `id_valid` = 1.
- **Wrap-around:** redirect to 8'hFE, no HALT in memory. Required response: `id_pc` = FE, FF, 00, 01 with `id_valid` = 1 throughout.
- **HALT:** the word at 8'h03 has opcode 111. Required response:
  - `id_pc` = 3 with `id_valid` = 1, `halted` = 1 from that same cycle.
  - Then `id_valid` = 0 and `imem_addr` = 3 for 10 cycles.
  - A redirect to 8'h20 clears `halted`, and fetch resumes at 8'h20.
- **Reset while HALTED:** assert `rst` while `halted` = 1. Required response: `halted` = 0, `id_valid` = 0, `imem_addr` = RESET_PC the next cycle; normal fetch follows.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage: PC owner, instruction fetch and IF/ID pipeline register with stall, redirect flush and HALT
module if_id_stage #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         IW       = 12,
    parameter logic [2:0] HALT_OP  = 3'b111
) (
    input  logic          clk,
    input  logic          rst,
    output logic [7:0]    imem_addr,
    input  logic [IW-1:0] imem_data,
    input  logic          stall,
    input  logic          redirect,
    input  logic [7:0]    redirect_pc,
    output logic          id_valid,
    output logic [7:0]    id_pc,
    output logic [7:0]    id_pc_plus1,
    output logic [IW-1:0] id_instr,
    output logic [2:0]    id_opcode,
    output logic [2:0]    id_rd,
    output logic [2:0]    id_rs,
    output logic [2:0]    id_imm3,
    output logic          halted
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t        state, state_n;
    logic [7:0]    pc, pc_n, id_pc_n;
    logic          id_valid_n;
    logic [IW-1:0] id_instr_n;
    assign imem_addr   = pc;
    assign id_pc_plus1 = id_pc + 8'd1;
    assign id_opcode   = id_instr[IW-1 -: 3];
    assign id_rd       = id_instr[IW-4 -: 3];
    assign id_rs       = id_instr[IW-7 -: 3];
    assign id_imm3     = id_instr[IW-10 -: 3];
    assign halted      = (state == HALTED);
    // next-state: redirect beats stall beats HALTED beats normal fetch
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        id_valid_n = id_valid;
        id_pc_n    = id_pc;
        id_instr_n = id_instr;
        if (redirect) begin
            pc_n       = redirect_pc;
            id_valid_n = 1'b0;
            state_n    = RUN;
        end else if (!stall) begin
            if (state == HALTED) begin
                id_valid_n = 1'b0;
            end else begin
                id_valid_n = 1'b1;
                id_pc_n    = pc;
                id_instr_n = imem_data;
                state_n    = (imem_data[IW-1 -: 3] == HALT_OP) ? HALTED : RUN;
                pc_n       = (imem_data[IW-1 -: 3] == HALT_OP) ? pc : pc + 8'd1;
            end
        end
    end
    // state, PC and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_pc    <= 8'h00;
            id_instr <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            id_valid <= id_valid_n;
            id_pc    <= id_pc_n;
            id_instr <= id_instr_n;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage driven by a behavioural instruction memory
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [7:0]  redirect_pc, imem_addr, id_pc, id_pc_plus1;
    logic [11:0] imem_data, id_instr;
    logic [2:0]  id_opcode, id_rd, id_rs, id_imm3;
    logic        id_valid, halted;
    logic [11:0] mem [256];
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [7:0]  pc;
        logic [11:0] instr;
        logic        h;
        logic [7:0]  addr;
    } exp_t;
    exp_t q[$];

    localparam logic [11:0] HW = {3'b111, 9'h0AB};

    if_id_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs),
        .id_imm3(id_imm3), .halted(halted)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    function automatic logic [11:0] w(input logic [7:0] a);
        return {3'b000, a[2:0], 3'b001, a[2:0]};
    endfunction

    function automatic exp_t mk(input string t, input logic v, input logic [7:0] p,
                                input logic [11:0] i, input logic h, input logic [7:0] a);
        exp_t e;
        e.tag = t; e.v = v; e.pc = p; e.instr = i; e.h = h; e.addr = a;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    // compare each queued expectation against the outputs half a cycle after its edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".valid"},  32'(id_valid),    32'(e.v));
            check({e.tag, ".pc"},     32'(id_pc),       32'(e.pc));
            check({e.tag, ".pc1"},    32'(id_pc_plus1), 32'(8'(e.pc + 8'd1)));
            check({e.tag, ".instr"},  32'(id_instr),    32'(e.instr));
            check({e.tag, ".opcode"}, 32'(id_opcode),   32'(e.instr[11:9]));
            check({e.tag, ".rd"},     32'(id_rd),       32'(e.instr[8:6]));
            check({e.tag, ".rs"},     32'(id_rs),       32'(e.instr[5:3]));
            check({e.tag, ".imm3"},   32'(id_imm3),     32'(e.instr[2:0]));
            check({e.tag, ".halted"}, 32'(halted),      32'(e.h));
            check({e.tag, ".addr"},   32'(imem_addr),   32'(e.addr));
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = w(8'(i));
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        tick(mk("reset", 0, 8'h00, 12'h000, 0, 8'h00));
        tick(mk("reset", 0, 8'h00, 12'h000, 0, 8'h00));
        rst = 1'b0;
        for (int k = 0; k <= 5; k++) tick(mk("seq", 1, 8'(k), w(8'(k)), 0, 8'(k + 1)));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) tick(mk("stall", 1, 8'h05, w(8'h05), 0, 8'h06));
        stall = 1'b0;
        for (int k = 6; k <= 15; k++) tick(mk("seq2", 1, 8'(k), w(8'(k)), 0, 8'(k + 1)));
        redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
        tick(mk("redir_flush", 0, 8'h0F, w(8'h0F), 0, 8'h40));
        redirect = 1'b0; stall = 1'b0;
        tick(mk("redir_tgt", 1, 8'h40, w(8'h40), 0, 8'h41));
        tick(mk("redir_next", 1, 8'h41, w(8'h41), 0, 8'h42));
        redirect = 1'b1; redirect_pc = 8'hFE;
        tick(mk("wrap_flush", 0, 8'h41, w(8'h41), 0, 8'hFE));
        redirect = 1'b0;
        tick(mk("wrap", 1, 8'hFE, w(8'hFE), 0, 8'hFF));
        tick(mk("wrap", 1, 8'hFF, w(8'hFF), 0, 8'h00));
        tick(mk("wrap", 1, 8'h00, w(8'h00), 0, 8'h01));
        tick(mk("wrap", 1, 8'h01, w(8'h01), 0, 8'h02));
        mem[3] = HW;
        tick(mk("pre_halt", 1, 8'h02, w(8'h02), 0, 8'h03));
        tick(mk("halt_word", 1, 8'h03, HW, 1, 8'h03));
        for (int k = 0; k < 10; k++) tick(mk("halted", 0, 8'h03, HW, 1, 8'h03));
        redirect = 1'b1; redirect_pc = 8'h20;
        tick(mk("unhalt", 0, 8'h03, HW, 0, 8'h20));
        redirect_pc = 8'h20;
        tick(mk("self_redir", 0, 8'h03, HW, 0, 8'h20));
        redirect = 1'b0;
        tick(mk("resume", 1, 8'h20, w(8'h20), 0, 8'h21));
        redirect = 1'b1; redirect_pc = 8'h02;
        tick(mk("rehalt_flush", 0, 8'h20, w(8'h20), 0, 8'h02));
        redirect = 1'b0;
        tick(mk("rehalt", 1, 8'h02, w(8'h02), 0, 8'h03));
        tick(mk("rehalt", 1, 8'h03, HW, 1, 8'h03));
        stall = 1'b1;
        tick(mk("halt_stall", 1, 8'h03, HW, 1, 8'h03));
        stall = 1'b0;
        tick(mk("halted2", 0, 8'h03, HW, 1, 8'h03));
        rst = 1'b1;
        tick(mk("rst_halted", 0, 8'h00, 12'h000, 0, 8'h00));
        rst = 1'b0;
        tick(mk("post_rst", 1, 8'h00, w(8'h00), 0, 8'h01));
        tick(mk("post_rst", 1, 8'h01, w(8'h01), 0, 8'h02));
        tick(mk("post_rst", 1, 8'h02, w(8'h02), 0, 8'h03));
        @(negedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
